car_sensor_fsm: RTL and testbench
=================================

# car_sensor_fsm

Decodes two gate-mounted photo sensors (outer A, inner B) into one-cycle `incr`/`decr` pulses that drive the occupancy up/down counter directly. A complete inward sequence produces one `incr`; a complete outward sequence produces one `decr`. Illegal sensor patterns and stalled sequences raise `fault`. The block sits between the board GPIO sensor pins and the occupancy counter.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per sensor input (≥2).
- `TIMEOUT`, default 1000: clk cycles a mid-sequence state may hold unchanged before faulting (≥2).
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `sens_a`  in  1  outer sensor, 1 = beam blocked. Asynchronous to clk.
- `sens_b`  in  1  inner sensor, 1 = beam blocked. Asynchronous to clk.
- `incr`  out  1  one-cycle pulse: car fully entered. Connects to counter `incr`.
- `decr`  out  1  one-cycle pulse: car fully exited. Connects to counter `decr`.
- `busy`  out  1  FSM is mid-sequence (any EN*/EX* state).
- `fault`  out  1  FSM is in ERR.

## Operation
- `sens_a` and `sens_b` each pass through a `SYNC_STAGES`-deep flop chain. The FSM sees only the synchronized pair `ab = {a_s, b_s}`.
- States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR.
- IDLE: 00 stay; 10→EN1; 01→EX1; 11→ERR.
- EN1 (10): 10 stay; 11→EN2; 00→IDLE (car backed out, no pulse); 01→ERR.
- EN2 (11): 11 stay; 01→EN3; 10→EN1; 00→ERR.
- EN3 (01): 01 stay; 00→IDLE with `incr`; 11→EN2; 10→ERR.
- EX1 (01): 01 stay; 11→EX2; 00→IDLE (no pulse); 10→ERR.
- EX2 (11): 11 stay; 10→EX3; 01→EX1; 00→ERR.
- EX3 (10): 10 stay; 00→IDLE with `decr`; 11→EX2; 01→ERR.
- ERR: stays while ab≠00; on ab=00 goes to IDLE. No pulses are produced from ERR.
- Timeout counter: counts clk cycles while in any EN*/EX* state. Clears on every state change and in IDLE/ERR. When the count reaches `TIMEOUT`-1 with no transition, next state is ERR. A legal transition on that same cycle takes priority and clears the count. Width is $clog2(TIMEOUT).
- `incr` and `decr` are never asserted in the same cycle. Neither is asserted on two consecutive cycles.
- Occupancy saturation belongs to the counter; this block pulses regardless of occupancy.

## Timing
- Reset asserted (reset=0): all synchronizer flops, state, and timeout count clear immediately. State = IDLE; `incr`=`decr`=`busy`=`fault`=0.
- Reset asserted mid-sequence: sequence is discarded and no pulse is generated. After release, the FSM starts in IDLE with synchronized inputs 0.
- A raw input change becomes visible to the FSM `SYNC_STAGES` edges later.
- `incr`/`decr` are registered. Each is high for exactly one cycle, on the edge where the state goes EN3/EX3→IDLE. That is `SYNC_STAGES`+1 edges after the raw pair settles to 00.
- `busy` and `fault` are decoded from the state register, so they update on the same edge as the state.
- Raw inputs changing together may land one cycle apart after synchronization. In that case the FSM follows the resulting legal path if one exists, otherwise it goes to ERR.

## Structure
- Package `car_sensor_pkg`:
  - `state_t` enum covering the 8 states.
  - Pattern constants `AB_NONE`=2'b00, `AB_OUT`=2'b10, `AB_BOTH`=2'b11, `AB_IN`=2'b01.
- Sub-module `input_sync`: a parameterized single-bit flop chain (`STAGES`, async active-low reset to 0), instantiated once per sensor.
- Top level contains the FSM, the timeout counter, and the output registers.

## Test plan
- Reset, then drive ab 00→10→11→01→00, each held 5 cycles → exactly one `incr` pulse, 3 edges after the final 00. `decr`=0 throughout; `busy` high only during the sequence.
- Drive ab 00→01→11→10→00 → exactly one `decr` pulse. Then repeat 20 entries chained to the occupancy counter → counter reads 16 while 20 `incr` pulses are seen.
- Drive ab 10→11→10→00 (partial entry, then back out) → no pulse, final state IDLE, `fault`=0.
- Jump ab 00→11, or 10→01 while in EN1 → `fault`=1 until ab returns to 00, then `fault`=0 one edge later, with no pulses.
- With `TIMEOUT`=8, hold ab=10 for 20 cycles → `fault` rises 8 cycles after entering EN1; ab=00 then clears it.
- Assert reset=0 while in EN3 → outputs go 0 asynchronously. Release, then ab=00 → no `incr`.

Source files
------------

// File: rtl/car_sensor_pkg.sv
// Shared types and sensor-pattern constants for the gate sensor decoder.
// Patterns are {a, b}, where a is the outer beam and b is the inner beam.
package car_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    ERR
  } state_t;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_OUT  = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_IN   = 2'b01;

  function automatic logic in_sequence(state_t s);
    return (s inside {EN1, EN2, EN3, EX1, EX2, EX3});
  endfunction

endpackage

// File: rtl/input_sync.sv
// Single-bit synchronizer chain for an asynchronous sensor input.
// The chain clears to 0 during reset.
module input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/car_sensor_fsm.sv
// Decodes the outer and inner gate beams into single-cycle incr and decr pulses
// for the occupancy counter. Illegal patterns and stalled sequences raise fault.
//
// state | meaning
// IDLE  | no car in the gate
// EN1   | entering, outer beam only
// EN2   | entering, both beams
// EN3   | entering, inner beam only
// EX1   | exiting, inner beam only
// EX2   | exiting, both beams
// EX3   | exiting, outer beam only
// ERR   | illegal pattern or timeout, waiting for both beams clear
module car_sensor_fsm
  import car_sensor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic incr,
  output logic decr,
  output logic busy,
  output logic fault
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          a_s;
  logic          b_s;
  logic [1:0]    ab;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          incr_nxt;
  logic          decr_nxt;

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (sens_a),
    .q     (a_s)
  );

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (sens_b),
    .q     (b_s)
  );

  assign ab = {a_s, b_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      incr  <= 1'b0;
      decr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      incr  <= incr_nxt;
      decr  <= decr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    incr_nxt  = 1'b0;
    decr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        case (ab)
          AB_OUT:  state_nxt = EN1;
          AB_IN:   state_nxt = EX1;
          AB_BOTH: state_nxt = ERR;
          default: state_nxt = IDLE;
        endcase
      end
      EN1: begin
        case (ab)
          AB_BOTH: state_nxt = EN2;
          AB_NONE: state_nxt = IDLE;
          AB_IN:   state_nxt = ERR;
          default: state_nxt = EN1;
        endcase
      end
      EN2: begin
        case (ab)
          AB_IN:   state_nxt = EN3;
          AB_OUT:  state_nxt = EN1;
          AB_NONE: state_nxt = ERR;
          default: state_nxt = EN2;
        endcase
      end
      EN3: begin
        case (ab)
          AB_NONE: begin
            state_nxt = IDLE;
            incr_nxt  = 1'b1;
          end
          AB_BOTH: state_nxt = EN2;
          AB_OUT:  state_nxt = ERR;
          default: state_nxt = EN3;
        endcase
      end
      EX1: begin
        case (ab)
          AB_BOTH: state_nxt = EX2;
          AB_NONE: state_nxt = IDLE;
          AB_OUT:  state_nxt = ERR;
          default: state_nxt = EX1;
        endcase
      end
      EX2: begin
        case (ab)
          AB_OUT:  state_nxt = EX3;
          AB_IN:   state_nxt = EX1;
          AB_NONE: state_nxt = ERR;
          default: state_nxt = EX2;
        endcase
      end
      EX3: begin
        case (ab)
          AB_NONE: begin
            state_nxt = IDLE;
            decr_nxt  = 1'b1;
          end
          AB_BOTH: state_nxt = EX2;
          AB_IN:   state_nxt = ERR;
          default: state_nxt = EX3;
        endcase
      end
      ERR: begin
        if (ab == AB_NONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Any legal move resets the stall timer, so only a hold can time out.
    if (in_sequence(state) && (state_nxt == state) && (cnt == CNT_LAST)) begin
      state_nxt = ERR;
    end

    cnt_nxt = '0;
    if (in_sequence(state) && (state_nxt == state)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  assign busy  = in_sequence(state);
  assign fault = (state == ERR);

endmodule

// File: tb/tb_car_sensor_fsm.sv
// Self-checking bench for car_sensor_fsm: a path-position reference model run
// on every cycle, table-driven sequences, directed corner cases and random walks.
module tb_car_sensor_fsm;

  localparam int T = 8;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_IN   = 2'd1;
  localparam logic [1:0] M_OUT  = 2'd2;
  localparam logic [1:0] M_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] pos;
    int         hold;
    logic       pi;
    logic       pd;
  } mst_t;

  typedef struct {
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] p3;
    int         ni;
    int         nd;
    bit         fs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic incr, decr, busy, fault;

  mst_t ms;
  logic [1:0] sy0, sy1;

  int total = 0;
  int bad = 0;
  int n_incr = 0;
  int n_decr = 0;
  int n_fault = 0;
  int occ = 0;
  bit chk_en = 1'b0;
  logic prev_pulse = 1'b0;

  car_sensor_fsm #(.SYNC_STAGES(2), .TIMEOUT(T)) dut (
    .clk    (clk),
    .reset  (reset),
    .sens_a (sens_a),
    .sens_b (sens_b),
    .incr   (incr),
    .decr   (decr),
    .busy   (busy),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  // A car walks a three-step path of beam patterns; position on that path
  // plus how long it has been held is all the model needs.
  function automatic mst_t step(mst_t m, logic [1:0] ab);
    logic [1:0] path [3];
    mst_t n;
    n = m;
    n.pi = 1'b0;
    n.pd = 1'b0;
    if (m.mode == M_IN) path = '{2'b10, 2'b11, 2'b01};
    else                path = '{2'b01, 2'b11, 2'b10};
    case (m.mode)
      M_IDLE: begin
        n.pos = 2'd0;
        n.hold = 0;
        if (ab == 2'b10)      n.mode = M_IN;
        else if (ab == 2'b01) n.mode = M_OUT;
        else if (ab == 2'b11) n.mode = M_ERR;
      end
      M_ERR: begin
        if (ab == 2'b00) n.mode = M_IDLE;
      end
      default: begin
        if (ab == path[m.pos]) begin
          if (m.hold == T - 1) n.mode = M_ERR;
          else n.hold = m.hold + 1;
        end else if (m.pos < 2 && ab == path[m.pos + 1]) begin
          n.pos = m.pos + 2'd1;
          n.hold = 0;
        end else if (m.pos > 0 && ab == path[m.pos - 1]) begin
          n.pos = m.pos - 2'd1;
          n.hold = 0;
        end else if (ab == 2'b00 && m.pos == 0) begin
          n.mode = M_IDLE;
        end else if (ab == 2'b00 && m.pos == 2) begin
          n.mode = M_IDLE;
          if (m.mode == M_IN) n.pi = 1'b1;
          else n.pd = 1'b1;
        end else begin
          n.mode = M_ERR;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms  <= '0;
      sy0 <= 2'b00;
      sy1 <= 2'b00;
    end else begin
      ms  <= step(ms, sy1);
      sy1 <= sy0;
      sy0 <= {sens_a, sens_b};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("model_incr", int'(incr), int'(ms.pi));
      check("model_decr", int'(decr), int'(ms.pd));
      check("model_busy", int'(busy), int'(ms.mode == M_IN || ms.mode == M_OUT));
      check("model_fault", int'(fault), int'(ms.mode == M_ERR));
      check("incr_decr_excl", int'(incr & decr), 0);
      check("no_back_to_back", int'((incr | decr) & prev_pulse), 0);
    end
    prev_pulse = incr | decr;
    n_incr += int'(incr);
    n_decr += int'(decr);
    n_fault += int'(fault);
    if (incr && occ < 16) occ++;
    if (decr && occ > 0) occ--;
  endtask

  task automatic set_ab(input logic [1:0] v);
    sens_a = v[1];
    sens_b = v[0];
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    set_ab(v);
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    occ = 0;
  endtask

  vec_t tv [10];
  int   si, sd, sf;

  initial begin
    tv[0] = '{2'b10, 2'b11, 2'b01, 2'b00, 1, 0, 1'b0};
    tv[1] = '{2'b01, 2'b11, 2'b10, 2'b00, 0, 1, 1'b0};
    tv[2] = '{2'b10, 2'b11, 2'b10, 2'b00, 0, 0, 1'b0};
    tv[3] = '{2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 1'b1};
    tv[4] = '{2'b10, 2'b01, 2'b01, 2'b00, 0, 0, 1'b1};
    tv[5] = '{2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1'b0};
    tv[6] = '{2'b10, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1};
    tv[7] = '{2'b01, 2'b11, 2'b01, 2'b00, 0, 0, 1'b0};
    tv[8] = '{2'b10, 2'b11, 2'b01, 2'b10, 0, 0, 1'b1};
    tv[9] = '{2'b01, 2'b11, 2'b10, 2'b11, 0, 0, 1'b1};

    #2 reset = 1'b0;
    #1;
    check("rst_incr", int'(incr), 0);
    check("rst_decr", int'(decr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    tick();
    tick();
    reset = 1'b1;
    chk_en = 1'b1;
    drive(2'b00, 4);

    // Inward sequence: incr exactly three edges after the raw pair reaches 00.
    si = n_incr; sd = n_decr;
    drive(2'b10, 5);
    drive(2'b11, 5);
    drive(2'b01, 5);
    set_ab(2'b00);
    tick();
    tick();
    check("lat_busy_before", int'(busy), 1);
    check("lat_incr_early", int'(incr), 0);
    tick();
    check("lat_incr_on_time", int'(incr), 1);
    check("lat_busy_after", int'(busy), 0);
    tick();
    check("lat_incr_one_cycle", int'(incr), 0);
    drive(2'b00, 3);
    check("lat_incr_count", n_incr - si, 1);
    check("lat_decr_count", n_decr - sd, 0);

    foreach (tv[k]) begin
      si = n_incr; sd = n_decr; sf = n_fault;
      drive(tv[k].p0, 4);
      drive(tv[k].p1, 4);
      drive(tv[k].p2, 4);
      drive(tv[k].p3, 4);
      drive(2'b00, 6);
      check($sformatf("vec%0d_incr", k), n_incr - si, tv[k].ni);
      check($sformatf("vec%0d_decr", k), n_decr - sd, tv[k].nd);
      check($sformatf("vec%0d_fault_seen", k), int'(n_fault > sf), int'(tv[k].fs));
      check($sformatf("vec%0d_end_fault", k), int'(fault), 0);
      check($sformatf("vec%0d_end_busy", k), int'(busy), 0);
    end

    // Twenty entries into a counter that saturates at 16.
    pulse_reset();
    drive(2'b00, 3);
    si = n_incr;
    for (int e = 0; e < 20; e++) begin
      drive(2'b10, 2);
      drive(2'b11, 2);
      drive(2'b01, 2);
      drive(2'b00, 4);
    end
    check("occ_saturated", occ, 16);
    check("occ_incr_pulses", n_incr - si, 20);

    // Stall in EN1: fault rises eight edges after EN1 is entered.
    set_ab(2'b10);
    tick();
    tick();
    check("to_busy_pre", int'(busy), 0);
    tick();
    check("to_busy_en1", int'(busy), 1);
    repeat (7) tick();
    check("to_fault_early", int'(fault), 0);
    tick();
    check("to_fault_rise", int'(fault), 1);
    repeat (9) tick();
    set_ab(2'b00);
    tick();
    tick();
    check("to_fault_hold", int'(fault), 1);
    tick();
    check("to_fault_clear", int'(fault), 0);
    drive(2'b00, 3);

    // Asynchronous reset while in EN3 discards the sequence.
    si = n_incr;
    drive(2'b10, 3);
    drive(2'b11, 3);
    drive(2'b01, 4);
    check("ar_busy_en3", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy_async", int'(busy), 0);
    check("ar_fault_async", int'(fault), 0);
    check("ar_incr_async", int'(incr), 0);
    tick();
    reset = 1'b1;
    drive(2'b00, 6);
    check("ar_no_incr", n_incr - si, 0);

    for (int r = 0; r < 300; r++) begin
      case ($urandom_range(0, 3))
        0: begin
          drive(2'b10, $urandom_range(1, 10));
          drive(2'b11, $urandom_range(1, 10));
          drive(2'b01, $urandom_range(1, 10));
          drive(2'b00, $urandom_range(1, 6));
        end
        1: begin
          drive(2'b01, $urandom_range(1, 10));
          drive(2'b11, $urandom_range(1, 10));
          drive(2'b10, $urandom_range(1, 10));
          drive(2'b00, $urandom_range(1, 6));
        end
        default: begin
          drive(2'($urandom_range(0, 3)), $urandom_range(1, 12));
        end
      endcase
    end
    drive(2'b00, 6);
    check("final_idle_busy", int'(busy), 0);
    check("final_idle_fault", int'(fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
